lsu_axi: RTL and testbench
==========================

LSU_AXI -- requirements
Module: lsu_axi

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus and data width; legal values are 32 and 64.
REQ-003 SHALL have port clk  input  1  single clock; all logic rises on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle if req_valid.
REQ-007 SHALL have port req_wen  input  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port req_wdata  input  DATA_W  store data, LSB-justified.
REQ-010 SHALL have port req_size  input  2  0=byte, 1=half, 2=word, 3=dword.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  consumer takes response.
REQ-014 SHALL have port resp_rdata  output  DATA_W  extended load data; 0 for stores.
REQ-015 SHALL have port resp_err  output  2  0=ok, 1=bus error, 2=misaligned/illegal size.
REQ-016 SHALL have port mem  axi4_lite_interface.master  --  AXI4-Lite master (ar/r/aw/w/b channels).

Function
REQ-017 SHALL implement FSM states IDLE, AR, R, AW_W, B, RESP; req_ready=1 only in IDLE.
REQ-018 On handshake in IDLE, SHALL register all req_* fields; go to AR for a load, AW_W for a store.
REQ-019 Byte offset off = req_addr[log2(DATA_W/8)-1:0]; araddr/awaddr SHALL be req_addr with offset bits cleared.
REQ-020 In AR: arvalid=1; SHALL go to R on arready. In R: rready=1; SHALL go to RESP on rvalid, registering rdata.
REQ-021 Load data SHALL be rdata shifted right by off*8, truncated to 2^size bytes, then extended per req_unsigned; size 3 unextended.
REQ-022 In AW_W: awvalid and wvalid SHALL assert together; each SHALL drop independently after its own handshake (done flags); go to B when both are done, including same-cycle completion.
REQ-023 wdata SHALL be req_wdata shifted left by off*8; wstrb SHALL be a (2^size)-bit ones mask shifted left by off, truncated to DATA_W/8 bits.
REQ-024 In B: bready=1; SHALL go to RESP on bvalid; bready=0 in all other states.
REQ-025 resp_err SHALL be 1 when rresp or bresp is nonzero; data SHALL still be returned for loads.
REQ-026 In RESP: resp_valid=1; resp_rdata and resp_err SHALL be stable until resp_ready, then IDLE; no request accepted in the RESP cycle.
REQ-027 Minimum latency, accept at cycle N with zero-wait slave: resp_valid at N+3 for both loads and stores.
REQ-028 req_size=3 with DATA_W=32 SHALL go IDLE->RESP at N+1 with resp_err=2 and no bus valid.
REQ-029 Bus valids SHALL be held until handshake, never withdrawn, and their payload SHALL be stable.

Reset
REQ-030 On rst: state=IDLE; arvalid, awvalid, wvalid, rready, bready, resp_valid=0; resp_rdata=0; resp_err=0; done flags cleared.
REQ-031 Reset mid-transaction SHALL abandon it without completing; the slave is reset by the same rst.

Configuration
REQ-032 Macro LSU_MISALIGN_CHECK_EN defined: when addr is not a multiple of 2^size, the block SHALL go IDLE->RESP at N+1 with resp_err=2, asserting no bus valid.
REQ-033 LSU_MISALIGN_CHECK_EN undefined: misaligned requests SHALL be issued; lanes beyond the bus SHALL be dropped from wstrb and zero-filled on load; resp_err never 2 except by REQ-028.

Verification
REQ-034 Load: size=0, unsigned=0, addr=0x8000_0003, rdata=0x80FF_FFFF, zero-wait -> araddr=0x8000_0000, resp_rdata=0xFFFF_FF80, resp_err=0 at N+3.
REQ-035 Store: size=1, addr=0x8000_0002, wdata=0x0000_ABCD -> wdata=0xABCD_0000, wstrb=0b1100; aw accepted cycle 1, w cycle 3 -> bready asserted only after both are accepted.
REQ-036 Backpressure: resp_ready low 5 cycles -> resp_valid and resp_rdata stable; req_ready=0 throughout.
REQ-037 Error: rresp=2'b10 on load -> resp_err=1; bresp=2'b11 on store -> resp_err=1.
REQ-038 With LSU_MISALIGN_CHECK_EN: size=2, addr=0x8000_0002 -> resp_err=2 at N+1, no arvalid. Without it: arvalid issued, resp_rdata upper half zero.

Source files
------------

// File: rtl/lsu_axi_if.sv
// AXI4-Lite bundle shared by the load/store unit (master) and its memory slave.
interface axi4_lite_interface #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/lsu_axi.sv
// Single-outstanding load/store unit driving an AXI4-Lite master port.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned requests with resp_err=2.
module lsu_axi #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [1:0]        resp_err,
   axi4_lite_interface.master mem
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW_W = 3'd3;
   localparam logic [2:0] S_B    = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   logic [2:0]        r_state;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic              r_aw_done;
   logic              r_w_done;
   logic [DATA_W-1:0] r_resp_rdata;
   logic [1:0]        r_resp_err;

   logic [OFF_W-1:0]  w_off;
   logic              w_awvalid;
   logic              w_wvalid;
   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_aw_fin;
   logic              w_w_fin;
   logic              w_req_bad;
   logic [STRB_W-1:0] w_strb_base;
   logic [DATA_W-1:0] w_ld_shift;
   logic [DATA_W-1:0] w_ld_mask;
   logic              w_ld_sign;
   logic [DATA_W-1:0] w_ld_data;

   assign w_off      = r_addr[OFF_W-1:0];
   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

   // Valids are pure functions of registered state, so they cannot be withdrawn early.
   assign w_awvalid = (r_state == S_AW_W) && !r_aw_done;
   assign w_wvalid  = (r_state == S_AW_W) && !r_w_done;
   assign w_aw_hs   = w_awvalid && mem.awready;
   assign w_w_hs    = w_wvalid && mem.wready;
   assign w_aw_fin  = r_aw_done || w_aw_hs;
   assign w_w_fin   = r_w_done || w_w_hs;

   assign mem.arvalid = (r_state == S_AR);
   assign mem.araddr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign mem.rready  = (r_state == S_R);
   assign mem.awvalid = w_awvalid;
   assign mem.awaddr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign mem.wvalid  = w_wvalid;
   assign mem.wdata   = r_wdata << {w_off, 3'b000};
   assign mem.wstrb   = w_strb_base << w_off;
   assign mem.bready  = (r_state == S_B);

   always_comb begin
      case (r_size)
         2'd0:    w_strb_base = STRB_W'(1);
         2'd1:    w_strb_base = STRB_W'(3);
         2'd2:    w_strb_base = STRB_W'(15);
         default: w_strb_base = '1;
      endcase
   end

   always_comb begin
      w_req_bad = (req_size == 2'd3) && (DATA_W == 32);
`ifdef LSU_MISALIGN_CHECK_EN
      case (req_size)
         2'd1:    if (req_addr[0]) w_req_bad = 1'b1;
         2'd2:    if (req_addr[1:0] != 2'b00) w_req_bad = 1'b1;
         2'd3:    if (req_addr[2:0] != 3'b000) w_req_bad = 1'b1;
         default: ;
      endcase
`endif
   end

   // Right shift zero-fills lanes beyond the bus before the extension is applied.
   assign w_ld_shift = mem.rdata >> {w_off, 3'b000};

   always_comb begin
      w_ld_mask = '1;
      w_ld_sign = 1'b0;
      case (r_size)
         2'd0: begin
            w_ld_mask = DATA_W'(8'hFF);
            w_ld_sign = w_ld_shift[7];
         end
         2'd1: begin
            w_ld_mask = DATA_W'(16'hFFFF);
            w_ld_sign = w_ld_shift[15];
         end
         2'd2: begin
            w_ld_mask = DATA_W'(32'hFFFF_FFFF);
            w_ld_sign = w_ld_shift[31];
         end
         default: ;
      endcase
      if (r_unsigned) w_ld_sign = 1'b0;
      w_ld_data = (w_ld_shift & w_ld_mask) | ({DATA_W{w_ld_sign}} & ~w_ld_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wen        <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_size       <= 2'd0;
         r_unsigned   <= 1'b0;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_wen      <= req_wen;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_aw_done  <= 1'b0;
                  r_w_done   <= 1'b0;
                  if (w_req_bad) begin
                     r_resp_rdata <= '0;
                     r_resp_err   <= 2'd2;
                     r_state      <= S_RESP;
                  end else if (req_wen) begin
                     r_state <= S_AW_W;
                  end else begin
                     r_state <= S_AR;
                  end
               end
            end
            S_AR: begin
               if (mem.arready) r_state <= S_R;
            end
            S_R: begin
               if (mem.rvalid) begin
                  r_resp_rdata <= w_ld_data;
                  r_resp_err   <= (mem.rresp != 2'b00) ? 2'd1 : 2'd0;
                  r_state      <= S_RESP;
               end
            end
            S_AW_W: begin
               if (w_aw_hs) r_aw_done <= 1'b1;
               if (w_w_hs)  r_w_done  <= 1'b1;
               if (w_aw_fin && w_w_fin) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= S_B;
               end
            end
            S_B: begin
               if (mem.bvalid) begin
                  r_resp_rdata <= '0;
                  r_resp_err   <= (mem.bresp != 2'b00) ? 2'd1 : 2'd0;
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_axi.sv
// Directed bench for lsu_axi; the bench itself plays the AXI4-Lite slave.
module tb_lsu_axi;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;

   int n_err = 0;
   int n_checks = 0;

   axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) axi ();

   lsu_axi #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wen      (req_wen),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem          (axi.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns);
      req_valid    = 1'b1;
      req_wen      = wen;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
   endtask

   // Zero-wait load: accept, AR handshake, R beat; returns with the DUT in RESP.
   task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rdata, input logic [1:0] rresp);
      set_req(1'b0, addr, 32'h0, size, uns);
      axi.arready = 1'b1;
      step();
      req_valid   = 1'b0;
      step();
      axi.arready = 1'b0;
      axi.rvalid  = 1'b1;
      axi.rdata   = rdata;
      axi.rresp   = rresp;
      step();
      axi.rvalid  = 1'b0;
      axi.rresp   = 2'b00;
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
   endtask

   initial begin
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rdata   = '0;
      axi.rresp   = 2'b00;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = 2'b00;

      step();
      step();
      check("rst_resp_valid", resp_valid, 0);
      check("rst_arvalid", axi.arvalid, 0);
      check("rst_awvalid", axi.awvalid, 0);
      check("rst_wvalid", axi.wvalid, 0);
      check("rst_rready", axi.rready, 0);
      check("rst_bready", axi.bready, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", resp_err, 0);
      rst = 1'b0;
      step();
      check("idle_req_ready", req_ready, 1);

      // Signed byte load at offset 3, zero-wait slave
      set_req(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0);
      axi.arready = 1'b1;
      step();
      req_valid = 1'b0;
      check("ld_arvalid", axi.arvalid, 1);
      check("ld_araddr", axi.araddr, 32'h8000_0000);
      check("ld_req_ready_busy", req_ready, 0);
      step();
      axi.arready = 1'b0;
      check("ld_rready", axi.rready, 1);
      check("ld_arvalid_drop", axi.arvalid, 0);
      axi.rvalid = 1'b1;
      axi.rdata  = 32'h80FF_FFFF;
      step();
      axi.rvalid = 1'b0;
      check("ld_resp_valid_n3", resp_valid, 1);
      check("ld_rdata", resp_rdata, 32'hFFFF_FF80);
      check("ld_err", resp_err, 0);
      check("ld_rready_drop", axi.rready, 0);
      ack();
      check("ld_back_idle", req_ready, 1);
      check("ld_resp_done", resp_valid, 0);

      // Unsigned half with consumer backpressure and a pending request
      run_load(32'h8000_0002, 2'd1, 1'b1, 32'h8765_4321, 2'b00);
      set_req(1'b0, 32'h0000_0000, 32'h0, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("bp_resp_valid", resp_valid, 1);
         check("bp_rdata", resp_rdata, 32'h0000_8765);
         check("bp_req_ready", req_ready, 0);
         step();
      end
      req_valid = 1'b0;
      ack();
      check("bp_idle", req_ready, 1);

      run_load(32'h8000_0000, 2'd1, 1'b0, 32'h0000_F00F, 2'b00);
      check("ld_half_sext", resp_rdata, 32'hFFFF_F00F);
      ack();

      run_load(32'h8000_0004, 2'd2, 1'b0, 32'h1234_5678, 2'b10);
      check("ld_err_code", resp_err, 1);
      check("ld_err_data", resp_rdata, 32'h1234_5678);
      ack();

      // Half store at offset 2: AW taken in cycle 1, W in cycle 3
      set_req(1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 1'b0);
      step();
      req_valid = 1'b0;
      check("st_awvalid", axi.awvalid, 1);
      check("st_wvalid", axi.wvalid, 1);
      check("st_awaddr", axi.awaddr, 32'h8000_0000);
      check("st_wdata", axi.wdata, 32'hABCD_0000);
      check("st_wstrb", axi.wstrb, 4'b1100);
      axi.awready = 1'b1;
      step();
      axi.awready = 1'b0;
      check("st_aw_dropped", axi.awvalid, 0);
      check("st_w_held", axi.wvalid, 1);
      check("st_bready_c2", axi.bready, 0);
      step();
      check("st_w_held_c3", axi.wvalid, 1);
      check("st_wdata_c3", axi.wdata, 32'hABCD_0000);
      check("st_bready_c3", axi.bready, 0);
      axi.wready = 1'b1;
      step();
      axi.wready = 1'b0;
      check("st_bready", axi.bready, 1);
      check("st_w_dropped", axi.wvalid, 0);
      axi.bvalid = 1'b1;
      step();
      axi.bvalid = 1'b0;
      check("st_resp_valid", resp_valid, 1);
      check("st_resp_err", resp_err, 0);
      check("st_resp_rdata", resp_rdata, 0);
      ack();

      // Byte store, AW and W complete in the same cycle, slave error
      set_req(1'b1, 32'h8000_0001, 32'h0000_005A, 2'd0, 1'b0);
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      step();
      req_valid = 1'b0;
      check("sb_wdata", axi.wdata, 32'h0000_5A00);
      check("sb_wstrb", axi.wstrb, 4'b0010);
      step();
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      check("sb_bready_same_cycle", axi.bready, 1);
      check("sb_awvalid_off", axi.awvalid, 0);
      axi.bvalid = 1'b1;
      axi.bresp  = 2'b11;
      step();
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
      check("sb_resp_valid_n3", resp_valid, 1);
      check("sb_resp_err", resp_err, 1);
      ack();

      // Dword on a 32-bit bus is illegal
      set_req(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0);
      step();
      req_valid = 1'b0;
      check("ill_resp_valid_n1", resp_valid, 1);
      check("ill_resp_err", resp_err, 2);
      check("ill_no_arvalid", axi.arvalid, 0);
      check("ill_no_awvalid", axi.awvalid, 0);
      ack();

      // Misaligned word load / store
      set_req(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0);
      axi.arready = 1'b1;
      step();
      req_valid = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      axi.arready = 1'b0;
      check("mis_resp_valid_n1", resp_valid, 1);
      check("mis_resp_err", resp_err, 2);
      check("mis_no_arvalid", axi.arvalid, 0);
      ack();
      set_req(1'b1, 32'h8000_0003, 32'h1122_3344, 2'd2, 1'b0);
      step();
      req_valid = 1'b0;
      check("mis_st_err", resp_err, 2);
      check("mis_st_no_awvalid", axi.awvalid, 0);
      ack();
`else
      check("mis_arvalid", axi.arvalid, 1);
      check("mis_araddr", axi.araddr, 32'h8000_0000);
      step();
      axi.arready = 1'b0;
      axi.rvalid  = 1'b1;
      axi.rdata   = 32'hBEEF_1234;
      step();
      axi.rvalid  = 1'b0;
      check("mis_rdata_upper_zero", resp_rdata, 32'h0000_BEEF);
      check("mis_err", resp_err, 0);
      ack();
      set_req(1'b1, 32'h8000_0003, 32'h1122_3344, 2'd2, 1'b0);
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      step();
      req_valid = 1'b0;
      check("mis_st_wdata", axi.wdata, 32'h4400_0000);
      check("mis_st_wstrb", axi.wstrb, 4'b1000);
      step();
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b1;
      step();
      axi.bvalid  = 1'b0;
      check("mis_st_err", resp_err, 0);
      ack();
`endif

      // Reset while AR is outstanding abandons the load
      set_req(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
      step();
      req_valid = 1'b0;
      check("mid_arvalid", axi.arvalid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_arvalid", axi.arvalid, 0);
      check("mid_rst_idle", req_ready, 1);
      step();
      check("mid_rst_no_resp", resp_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
